reg_check_sequencer: RTL

// - Synthesizable, parametrised successor to the simulation register-check harness.
// - Resets the processor, lets it run for a programmed cycle budget, then takes over regfile read port A.
// - Steps through a loadable table of (register, expected value) pairs and compares each entry.
// - Reports busy/done/pass and an error count. Sits between processor rs1 and regfile ctrl_readRegA in the Wrapper.

---
 rtl/reg_check_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/reg_check_sequencer.sv
// Purpose: resets the processor, runs it for a programmed cycle budget, then takes
//          over regfile read port A and checks a table of (register, value) pairs.
// Latency: 1 cycle PRST + num_cycles RUN + num_checks*(1+REG_READ_LAT) CHK, then DONE.
// Backpressure: none; start is honoured only in IDLE/DONE, table writes only while idle.
//
// Ports:
//   clock, reset_n              system clock, asynchronous active-low reset
//   start, num_cycles,
//   num_checks                  run request; budget and entry count latched on start
//   tbl_we/idx/reg/val          expected-value table write port (ignored while busy)
//   proc_reset, run_en          processor control (PRST pulse, budget window)
//   test_mode, test_reg,
//   test_data                   regfile port-A takeover and returned read data
//   busy, done, pass, err_count run status
//   fail_idx, fail_actual       first failing entry and its read value
//
// Optional feature: define FIRST_FAIL_CAPTURE_EN to build the first-failure capture
// registers; otherwise fail_idx/fail_actual are tied to zero.

module reg_check_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_CHECKS   = 32,
  parameter int CYCLE_W      = 10,
  parameter int REG_READ_LAT = 0,
  localparam int IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  input  logic [IDX_W:0]        num_checks,
  input  logic                  tbl_we,
  input  logic [IDX_W-1:0]      tbl_idx,
  input  logic [REG_ADDR_W-1:0] tbl_reg,
  input  logic [DATA_WIDTH-1:0] tbl_val,
  output logic                  proc_reset,
  output logic                  run_en,
  output logic                  test_mode,
  output logic [REG_ADDR_W-1:0] test_reg,
  input  logic [DATA_WIDTH-1:0] test_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_W:0]        err_count,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  localparam logic [IDX_W:0] MAX_CHK = (IDX_W+1)'(NUM_CHECKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_RUN,
    S_CHK,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CYCLE_W-1:0]      budget_q;
  logic [CYCLE_W-1:0]      cyc_q;
  logic [IDX_W:0]          nchk_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    phase_q;
  logic [IDX_W:0]          err_q;

  logic [REG_ADDR_W-1:0]   tbl_reg_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   tbl_val_q [NUM_CHECKS];

  logic                    accept;
  logic                    last_beat;
  logic                    last_entry;
  logic                    mismatch;

  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // With a registered regfile the address is held for two cycles and the data
  // is sampled on the second; a combinational regfile is sampled on the first.
  assign last_beat  = (REG_READ_LAT == 0) || phase_q;
  assign last_entry = ({1'b0, idx_q} == (nchk_q - 1'b1));
  assign mismatch   = (state_q == S_CHK) && last_beat && (test_data != tbl_val_q[idx_q]);

  // Table is deliberately left out of reset so a loaded table survives a
  // mid-run reset_n pulse.
  always_ff @(posedge clock) begin
    if (tbl_we && !busy && ({1'b0, tbl_idx} < MAX_CHK)) begin
      tbl_reg_q[tbl_idx] <= tbl_reg;
      tbl_val_q[tbl_idx] <= tbl_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_PRST;
      end
      S_PRST: begin
        if (budget_q != '0)      state_d = S_RUN;
        else if (nchk_q == '0)   state_d = S_DONE;
        else                     state_d = S_CHK;
      end
      S_RUN: begin
        if (cyc_q == (budget_q - 1'b1)) state_d = (nchk_q == '0) ? S_DONE : S_CHK;
      end
      S_CHK: begin
        if (last_beat && last_entry) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      budget_q <= '0;
      cyc_q    <= '0;
      nchk_q   <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      err_q    <= '0;
    end else if (accept) begin
      budget_q <= num_cycles;
      nchk_q   <= (num_checks > MAX_CHK) ? MAX_CHK : num_checks;
      cyc_q    <= '0;
      idx_q    <= '0;
      phase_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      if (state_q == S_RUN) cyc_q <= cyc_q + 1'b1;
      if (state_q == S_CHK) begin
        phase_q <= !last_beat;
        if (last_beat) idx_q <= idx_q + 1'b1;
      end
      if (mismatch && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [IDX_W-1:0]      fail_idx_q;
  logic [DATA_WIDTH-1:0] fail_act_q;

  // err_q still reads zero on the first mismatch of a run, so it doubles as
  // the "nothing captured yet" flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fail_idx_q <= '0;
      fail_act_q <= '0;
    end else if (accept) begin
      fail_idx_q <= '0;
      fail_act_q <= '0;
    end else if (mismatch && (err_q == '0)) begin
      fail_idx_q <= idx_q;
      fail_act_q <= test_data;
    end
  end

  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_act_q;
`else
  assign fail_idx    = '0;
  assign fail_actual = '0;
`endif

  // Outputs decode straight from the state register so an async reset drops
  // test_mode (and releases the regfile port) without waiting for a clock.
  assign proc_reset = (state_q == S_PRST);
  assign run_en     = (state_q == S_RUN);
  assign test_mode  = (state_q == S_CHK);
  assign test_reg   = test_mode ? tbl_reg_q[idx_q] : '0;
  assign busy       = (state_q == S_PRST) || (state_q == S_RUN) || (state_q == S_CHK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;

endmodule
